// File: rtl/hps_ext_mbox_pkg.sv
// rtl/hps_ext_mbox_pkg.sv - shared codes, status layout and bus decoder states for the HPS mailbox
package hps_ext_mbox_pkg;

    localparam logic [15:0] CMD_BASE_DEFAULT = 16'h0034;

    typedef enum logic [1:0] {
        SUB_DATA   = 2'd0,
        SUB_FLAG   = 2'd1,
        SUB_STATUS = 2'd2,
        SUB_NONE   = 2'd3
    } sub_t;

    localparam int STAT_OVF_BIT   = 15;
    localparam int STAT_LEVEL_LSB = 0;
    localparam int STAT_LEVEL_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_SUB,
        ST_DATA,
        ST_END
    } bus_state_t;

    function automatic logic [15:0] status_word(input logic ovf, input logic [STAT_LEVEL_W-1:0] level);
        logic [15:0] w;
        w = '0;
        w[STAT_OVF_BIT] = ovf;
        w[STAT_LEVEL_LSB +: STAT_LEVEL_W] = level;
        return w;
    endfunction

endpackage

// File: rtl/hps_ext_mbox_if.sv
// rtl/hps_ext_mbox_if.sv - HPS-to-core receive stream (FIFO head) between mailbox and core
interface hps_ext_mbox_if #(
    parameter int WORDS = 3
);
    logic [WORDS*16-1:0] rx_data;
    logic [2:0]          rx_chan;
    logic                rx_valid;
    logic                rx_ready;

    modport master (output rx_data, output rx_chan, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_chan, input rx_valid, output rx_ready);
endinterface

// File: rtl/hps_ext_fifo.sv
// rtl/hps_ext_fifo.sv - synchronous FIFO with level output and same-cycle push/pop
module hps_ext_fifo #(
    parameter int WIDTH = 51,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    output logic [WIDTH-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level      = wr_ptr - rd_ptr;
    assign out_tvalid = (level != '0);
    assign do_pop     = out_tvalid && out_tready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign in_tready  = (level != (AW+1)'(DEPTH)) || do_pop;
    assign do_push    = in_tvalid && in_tready;
    assign out_tdata  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= in_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/hps_ext_mbox.sv
// rtl/hps_ext_mbox.sv - multi-channel HPS<->core mailbox bridge on the EXT_BUS
module hps_ext_mbox
    import hps_ext_mbox_pkg::*;
#(
    parameter logic [15:0] CMD_BASE   = CMD_BASE_DEFAULT,
    parameter int          CHANNELS   = 2,
    parameter int          WORDS      = 3,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    inout  wire  [35:0]                  EXT_BUS,
    input  logic [CHANNELS*WORDS*16-1:0] tx_data,
    input  logic [CHANNELS-1:0]          tx_valid,
    input  logic [2*CHANNELS-1:0]        ready_flags,
    hps_ext_mbox_if.master               rx,
    output logic                         rx_overflow,
    input  logic                         overflow_clr
);
    localparam int          MW       = WORDS*16;
    localparam int          LW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] CMD_LAST = CMD_BASE + 16'(2*CHANNELS - 1);

    logic [15:0] io_din;
    logic        io_strobe;
    logic        io_enable;
    logic [15:0] io_dout;
    logic        dout_en;

    assign io_din    = EXT_BUS[31:16];
    assign io_strobe = EXT_BUS[33];
    assign io_enable = EXT_BUS[34];
    assign EXT_BUS[15:0] = io_dout;
    assign EXT_BUS[32]   = dout_en;
    wire unused_bus = EXT_BUS[35];

    bus_state_t          state;
    bus_state_t          state_nxt;
    logic [9:0]          byte_cnt;
    logic                cmd_get;
    logic                cmd_set;
    logic [2:0]          cmd_chan;
    sub_t                sub;
    logic                fsel;
    logic [7:0]          req_cnt   [CHANNELS];
    logic [MW-1:0]       shadow    [CHANNELS];
    logic [MW-1:0]       hold      [CHANNELS];
    logic [CHANNELS-1:0] hold_pend;
    logic [MW-1:0]       asm_data;

    logic                cmd_hit;
    logic [3:0]          cmd_off;
    logic [7:0]          req_sel;
    logic [15:0]         get_word;
    logic                last_word;
    logic [CHANNELS-1:0] defer;
    logic                push_req;
    logic                fifo_in_tready;
    logic [LW-1:0]       fifo_level;
    logic [MW+2:0]       fifo_out;

    assign cmd_hit = (io_din >= CMD_BASE) && (io_din <= CMD_LAST);
    assign cmd_off = 4'(io_din - CMD_BASE);

    // A SET only lands in the FIFO once all WORDS data words have arrived.
    assign push_req = !io_enable && (state != ST_IDLE) && cmd_set && (byte_cnt >= 10'(WORDS + 1));

    always_comb begin
        req_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cmd_off[3:1] == 3'(c)) begin
                req_sel = req_cnt[c];
            end
        end
    end

    always_comb begin
        get_word = '0;
        case (sub)
            SUB_DATA: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (cmd_chan == 3'(c) && byte_cnt == 10'(w + 2)) begin
                            get_word = shadow[c][w*16 +: 16];
                        end
                    end
                end
            end
            SUB_FLAG: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (cmd_chan == 3'(c) && byte_cnt == 10'd2) begin
                        get_word = {15'd0, fsel ? ready_flags[2*c+1] : ready_flags[2*c]};
                    end
                end
            end
            SUB_STATUS: begin
                if (byte_cnt == 10'd2) begin
                    get_word = status_word(rx_overflow, 4'(fifo_level));
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        last_word = 1'b0;
        if (cmd_set) begin
            last_word = (byte_cnt == 10'(WORDS));
        end else if (sub == SUB_DATA) begin
            last_word = (byte_cnt == 10'(WORDS + 1));
        end else begin
            last_word = (byte_cnt == 10'd2);
        end
    end

    // A data GET on a channel freezes its shadow until the transaction ends.
    always_comb begin
        defer = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            defer[c] = io_enable && cmd_get && (cmd_chan == 3'(c)) &&
                       ((state == ST_SUB) ||
                        ((state == ST_DATA || state == ST_END) && sub == SUB_DATA));
        end
    end

    always_comb begin
        state_nxt = state;
        if (!io_enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_CMD: begin
                    state_nxt = ST_CMD;
                    if (io_strobe) begin
                        if (!cmd_hit) begin
                            state_nxt = ST_END;
                        end else if (cmd_off[0]) begin
                            state_nxt = ST_DATA;
                        end else begin
                            state_nxt = ST_SUB;
                        end
                    end
                end
                ST_SUB: begin
                    if (io_strobe) begin
                        state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (io_strobe && last_word) begin
                        state_nxt = ST_END;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            io_dout     <= '0;
            dout_en     <= 1'b0;
            byte_cnt    <= '0;
            cmd_get     <= 1'b0;
            cmd_set     <= 1'b0;
            cmd_chan    <= '0;
            sub         <= SUB_DATA;
            fsel        <= 1'b0;
            asm_data    <= '0;
            hold_pend   <= '0;
            rx_overflow <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                req_cnt[c] <= '0;
                shadow[c]  <= '0;
                hold[c]    <= '0;
            end
        end else begin
            if (!io_enable) begin
                io_dout  <= '0;
                dout_en  <= 1'b0;
                byte_cnt <= '0;
            end else if (io_strobe) begin
                io_dout <= '0;
                if (byte_cnt != 10'h3FF) begin
                    byte_cnt <= byte_cnt + 10'd1;
                end
                case (state)
                    ST_IDLE, ST_CMD: begin
                        dout_en  <= cmd_hit;
                        cmd_get  <= cmd_hit && !cmd_off[0];
                        cmd_set  <= cmd_hit && cmd_off[0];
                        cmd_chan <= cmd_off[3:1];
                        if (cmd_hit && !cmd_off[0]) begin
                            io_dout <= {8'd0, req_sel};
                        end
                    end
                    ST_SUB: begin
                        sub  <= sub_t'(io_din[1:0]);
                        fsel <= io_din[2];
                    end
                    ST_DATA: begin
                        if (cmd_set) begin
                            for (int w = 0; w < WORDS; w++) begin
                                if (byte_cnt == 10'(w + 1)) begin
                                    asm_data[w*16 +: 16] <= io_din;
                                end
                            end
                        end else begin
                            io_dout <= get_word;
                        end
                    end
                    default: ;
                endcase
            end

            for (int c = 0; c < CHANNELS; c++) begin
                if (tx_valid[c]) begin
                    req_cnt[c] <= req_cnt[c] + 8'd1;
                    if (defer[c]) begin
                        hold[c]      <= tx_data[c*MW +: MW];
                        hold_pend[c] <= 1'b1;
                    end else begin
                        shadow[c]    <= tx_data[c*MW +: MW];
                        hold_pend[c] <= 1'b0;
                    end
                end else if (!io_enable && hold_pend[c]) begin
                    shadow[c]    <= hold[c];
                    hold_pend[c] <= 1'b0;
                end
            end

            if (push_req && !fifo_in_tready) begin
                rx_overflow <= 1'b1;
            end else if (overflow_clr) begin
                rx_overflow <= 1'b0;
            end
        end
    end

    hps_ext_fifo #(
        .WIDTH (MW + 3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_sys),
        .rst_n      (reset_n),
        .in_tdata   ({cmd_chan, asm_data}),
        .in_tvalid  (push_req),
        .in_tready  (fifo_in_tready),
        .out_tdata  (fifo_out),
        .out_tvalid (rx.rx_valid),
        .out_tready (rx.rx_ready),
        .level      (fifo_level)
    );

    assign rx.rx_chan = fifo_out[MW +: 3];
    assign rx.rx_data = fifo_out[MW-1:0];
endmodule

// File: tb/tb_hps_ext_mbox.sv
// tb/tb_hps_ext_mbox.sv - self-checking bench for hps_ext_mbox against a transaction-level model
module tb_hps_ext_mbox;
    localparam int CH = 2;
    localparam int WD = 3;
    localparam int DEPTH = 4;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset_n;
    logic [15:0] io_din;
    logic        io_strobe;
    logic        io_enable;
    wire  [35:0] ext_bus;
    logic [CH*WD*16-1:0] tx_data;
    logic [CH-1:0]       tx_valid;
    logic [2*CH-1:0]     ready_flags;
    logic                rx_overflow;
    logic                overflow_clr;

    assign ext_bus[31:16] = io_din;
    assign ext_bus[33]    = io_strobe;
    assign ext_bus[34]    = io_enable;
    assign ext_bus[35]    = 1'b0;

    hps_ext_mbox_if #(.WORDS(WD)) rx_if ();

    hps_ext_mbox #(
        .CMD_BASE   (16'h0034),
        .CHANNELS   (CH),
        .WORDS      (WD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .EXT_BUS      (ext_bus),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .ready_flags  (ready_flags),
        .rx           (rx_if),
        .rx_overflow  (rx_overflow),
        .overflow_clr (overflow_clr)
    );

    logic [47:0] m_shadow [CH];
    logic [47:0] m_hold   [CH];
    bit          m_pend   [CH];
    logic [7:0]  m_req    [CH];
    logic [50:0] m_fifo   [$];
    bit          m_ovf;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_ovf = 0;
        for (int c = 0; c < CH; c++) begin
            m_shadow[c] = '0;
            m_hold[c]   = '0;
            m_pend[c]   = 0;
            m_req[c]    = '0;
        end
    endtask

    task automatic strobe(input logic [15:0] din, output logic [15:0] dout, output logic den);
        @(negedge clk_sys);
        io_din    = din;
        io_strobe = 1'b1;
        @(negedge clk_sys);
        io_strobe = 1'b0;
        dout = ext_bus[15:0];
        den  = ext_bus[32];
    endtask

    task automatic begin_tx();
        @(negedge clk_sys);
        io_enable = 1'b1;
    endtask

    task automatic end_tx();
        @(negedge clk_sys);
        io_enable = 1'b0;
        @(negedge clk_sys);
        for (int c = 0; c < CH; c++) begin
            if (m_pend[c]) begin
                m_shadow[c] = m_hold[c];
                m_pend[c]   = 0;
            end
        end
    endtask

    task automatic tx_post(input int ch, input logic [47:0] d, input bit deferred);
        @(negedge clk_sys);
        tx_data[ch*48 +: 48] = d;
        tx_valid[ch] = 1'b1;
        @(negedge clk_sys);
        tx_valid = '0;
        m_req[ch] = m_req[ch] + 8'd1;
        if (deferred) begin
            m_hold[ch] = d;
            m_pend[ch] = 1;
        end else begin
            m_shadow[ch] = d;
            m_pend[ch]   = 0;
        end
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_rxv"}, rx_if.rx_valid, m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            chk({tag, "_rxchan"}, rx_if.rx_chan, m_fifo[0][50:48]);
            chk({tag, "_rxdata"}, rx_if.rx_data, m_fifo[0][47:0]);
        end
        chk({tag, "_ovf"}, rx_overflow, m_ovf);
    endtask

    function automatic logic [15:0] exp_word(input int ch, input logic [1:0] sub, input logic fsel, input int k);
        if (k >= WD) return 16'd0;
        case (sub)
            2'd0:    return m_shadow[ch][16*k +: 16];
            2'd1:    return (k == 0) ? {15'd0, ready_flags[2*ch + int'(fsel)]} : 16'd0;
            2'd2:    return (k == 0) ? {m_ovf, 11'd0, 4'(m_fifo.size())} : 16'd0;
            default: return 16'd0;
        endcase
    endfunction

    task automatic do_get(input int ch, input logic [1:0] sub, input logic fsel, input string tag);
        logic [15:0] d;
        logic        e;
        begin_tx();
        strobe(16'h0034 + 16'(2*ch), d, e);
        chk({tag, "_req"}, d, {8'd0, m_req[ch]});
        chk({tag, "_en"}, e, 1'b1);
        strobe({13'd0, fsel, sub}, d, e);
        chk({tag, "_sub"}, d, 16'd0);
        for (int k = 0; k < WD + 1; k++) begin
            strobe(16'd0, d, e);
            chk($sformatf("%s_w%0d", tag, k), d, exp_word(ch, sub, fsel, k));
        end
        end_tx();
    endtask

    task automatic do_set(input int ch, input int n, input logic [95:0] words, input string tag);
        logic [15:0] d;
        logic        e;
        begin_tx();
        strobe(16'h0035 + 16'(2*ch), d, e);
        chk({tag, "_en"}, e, 1'b1);
        for (int k = 0; k < n; k++) begin
            strobe(words[16*k +: 16], d, e);
            chk($sformatf("%s_d%0d", tag, k), d, 16'd0);
        end
        end_tx();
        if (n >= WD) begin
            if (m_fifo.size() == DEPTH) m_ovf = 1;
            else m_fifo.push_back({3'(ch), words[47:0]});
        end
        check_rx(tag);
    endtask

    task automatic do_pop(input string tag);
        @(negedge clk_sys);
        rx_if.rx_ready = 1'b1;
        @(negedge clk_sys);
        rx_if.rx_ready = 1'b0;
        if (m_fifo.size() != 0) void'(m_fifo.pop_front());
        check_rx(tag);
    endtask

    initial begin
        logic [15:0] d;
        logic        e;
        logic [47:0] old0;
        logic [47:0] new0;
        logic [95:0] rw;

        reset_n = 1'b0;
        io_din = '0;
        io_strobe = 1'b0;
        io_enable = 1'b0;
        tx_data = '0;
        tx_valid = '0;
        ready_flags = '0;
        overflow_clr = 1'b0;
        rx_if.rx_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_sys);
        chk("rst_dout", ext_bus[15:0], 16'd0);
        chk("rst_douten", ext_bus[32], 1'b0);
        check_rx("rst");
        reset_n = 1'b1;
        @(negedge clk_sys);

        tx_post(1, {16'h3333, 16'h2222, 16'h1111}, 0);
        do_get(1, 2'd0, 1'b0, "get1");

        do_set(0, 3, {48'd0, 16'h000C, 16'h000B, 16'h000A}, "set_abc");
        do_set(1, 2, {64'd0, 16'h5555, 16'h4444}, "set_short");
        do_pop("pop_abc");

        for (int i = 0; i < 5; i++) begin
            rw = {$urandom, $urandom, $urandom};
            do_set(i % CH, 3, rw, $sformatf("fill%0d", i));
        end
        do_get(0, 2'd2, 1'b0, "stat_full");
        @(negedge clk_sys);
        overflow_clr = 1'b1;
        @(negedge clk_sys);
        overflow_clr = 1'b0;
        m_ovf = 0;
        chk("ovf_clr", rx_overflow, 1'b0);
        for (int i = 0; i < DEPTH; i++) do_pop($sformatf("drain%0d", i));

        old0 = {$urandom, $urandom};
        new0 = {$urandom, $urandom};
        tx_post(0, old0, 0);
        begin_tx();
        strobe(16'h0034, d, e);
        chk("dfr_req", d, {8'd0, m_req[0]});
        strobe(16'h0000, d, e);
        strobe(16'h0000, d, e);
        chk("dfr_w0", d, old0[15:0]);
        tx_post(0, new0, 1);
        strobe(16'h0000, d, e);
        chk("dfr_w1", d, old0[31:16]);
        strobe(16'h0000, d, e);
        chk("dfr_w2", d, old0[47:32]);
        end_tx();
        do_get(0, 2'd0, 1'b0, "dfr_next");

        begin_tx();
        for (int k = 0; k < 4; k++) begin
            strobe((k == 0) ? 16'h0040 : 16'(k), d, e);
            chk($sformatf("oor_d%0d", k), d, 16'd0);
            chk($sformatf("oor_en%0d", k), e, 1'b0);
        end
        end_tx();
        check_rx("oor");

        ready_flags = 4'b0100;
        do_get(1, 2'd1, 1'b0, "flag10");
        do_get(1, 2'd1, 1'b1, "flag11");
        do_get(0, 2'd3, 1'b0, "sub3");

        for (int i = 0; i < 24; i++) begin
            int op;
            int ch;
            op = $urandom_range(0, 3);
            ch = $urandom_range(0, CH - 1);
            case (op)
                0: tx_post(ch, {$urandom, $urandom}, 0);
                1: do_set(ch, $urandom_range(1, 4), {$urandom, $urandom, $urandom}, $sformatf("rset%0d", i));
                2: begin
                    ready_flags = 4'($urandom);
                    do_get(ch, 2'($urandom_range(0, 3)), 1'($urandom), $sformatf("rget%0d", i));
                end
                default: do_pop($sformatf("rpop%0d", i));
            endcase
        end

        if (m_fifo.size() == 0) do_set(1, 3, {$urandom, $urandom, $urandom}, "pre_rst");
        begin_tx();
        strobe(16'h0035, d, e);
        strobe(16'h1234, d, e);
        strobe(16'h5678, d, e);
        @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        model_reset();
        chk("mrst_dout", ext_bus[15:0], 16'd0);
        chk("mrst_douten", ext_bus[32], 1'b0);
        check_rx("mrst");
        reset_n = 1'b1;
        io_enable = 1'b0;
        @(negedge clk_sys);
        do_set(0, 3, {48'd0, 16'hBEEF, 16'hCAFE, 16'hF00D}, "post_rst");
        do_get(1, 2'd0, 1'b0, "post_rst_get");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
